// File: rtl/adc_det_pkg.sv
// Shared types and helpers for the multi-channel ADC window detector.
// Sample width and window depth are fixed here and used by every channel.
package adc_det_pkg;

  localparam int DW       = 16;
  localparam int LOG2_WIN = 3;
  localparam int WIN      = 1 << LOG2_WIN;
  localparam int SUMW     = DW + LOG2_WIN;

  typedef enum logic [1:0] {
    FILL,
    ARMED,
    ACTIVE,
    HOLDOFF
  } det_state_t;

  // Two's complement to offset binary: flip the sign bit.
  function automatic logic [DW-1:0] to_offset_binary(input logic [DW-1:0] s);
    return s ^ {1'b1, {(DW-1){1'b0}}};
  endfunction

endpackage

// File: rtl/adc_det_chan.sv
// One detector channel: moving-average window, detection FSM and overflow counter.
// Build option COMP_HYST_EN selects thr_lo as the release threshold.
module adc_det_chan
  import adc_det_pkg::*;
#(
  parameter int HOLD_LEN = 4,
  parameter int OFW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_of,
  input  logic [DW-1:0] thr_hi,
  input  logic [DW-1:0] thr_lo,
  input  logic          of_clr,
  output logic          m_valid,
  output logic [DW-1:0] avg_out,
  output logic          det,
  output logic          det_pulse,
  output logic [OFW-1:0] of_cnt
);

  localparam int HCW = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;

  logic [DW-1:0]       win_mem [WIN];
  logic [LOG2_WIN-1:0] wr_ptr;
  logic [SUMW-1:0]     sum;
  logic [SUMW-1:0]     sum_next;
  logic [LOG2_WIN:0]   fill_cnt;
  logic [DW-1:0]       u_new;
  det_state_t          state;
  logic [HCW-1:0]      hold_cnt;
  logic                release_hit;

  always_comb begin
    u_new    = to_offset_binary(s_data);
    sum_next = sum + SUMW'(u_new) - SUMW'(win_mem[wr_ptr]);
  end

  // NOTE: the window memory is reset so the running sum stays consistent with
  // its contents; a refill after reset subtracts zeros, never stale samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) win_mem[i] <= '0;
      wr_ptr   <= '0;
      sum      <= '0;
      fill_cnt <= '0;
      m_valid  <= 1'b0;
      avg_out  <= '0;
    end else begin
      m_valid <= 1'b0;
      if (s_valid) begin
        win_mem[wr_ptr] <= u_new;
        wr_ptr          <= wr_ptr + LOG2_WIN'(1);
        sum             <= sum_next;
        avg_out         <= sum_next[SUMW-1:LOG2_WIN];
        if (fill_cnt != (LOG2_WIN+1)'(WIN)) fill_cnt <= fill_cnt + (LOG2_WIN+1)'(1);
        m_valid <= (fill_cnt >= (LOG2_WIN+1)'(WIN-1));
      end
    end
  end

`ifdef COMP_HYST_EN
  assign release_hit = (avg_out < thr_lo);
`else
  assign release_hit = (avg_out <= thr_hi);
  logic unused_thr_lo;
  assign unused_thr_lo = ^thr_lo;
`endif

  // The FSM runs one cycle behind the window, on the freshly registered average.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      det       <= 1'b0;
      det_pulse <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      det_pulse <= 1'b0;
      if (m_valid) begin
        unique case (state)
          FILL: state <= ARMED;
          ARMED: begin
            if (avg_out > thr_hi) begin
              state     <= ACTIVE;
              det       <= 1'b1;
              det_pulse <= 1'b1;
            end
          end
          ACTIVE: begin
            if (release_hit) begin
              det      <= 1'b0;
              hold_cnt <= '0;
              state    <= (HOLD_LEN == 0) ? ARMED : HOLDOFF;
            end
          end
          HOLDOFF: begin
            if (hold_cnt == HCW'(HOLD_LEN - 1)) state <= ARMED;
            else hold_cnt <= hold_cnt + HCW'(1);
          end
          default: state <= FILL;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      of_cnt <= '0;
    end else if (of_clr) begin
      of_cnt <= '0;
    end else if (s_valid && s_of && !(&of_cnt)) begin
      of_cnt <= of_cnt + OFW'(1);
    end
  end

endmodule

// File: rtl/adc_window_detector.sv
// Multi-channel ADC window detector: NCH independent adc_det_chan instances.
// Build option COMP_HYST_EN enables the thr_lo release threshold.
module adc_window_detector
  import adc_det_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int HOLDOFF = 4,
  parameter int OFW     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [NCH*DW-1:0] s_data,
  input  logic [NCH-1:0]    s_of,
  input  logic [DW-1:0]     thr_hi,
  input  logic [DW-1:0]     thr_lo,
  input  logic              of_clr,
  output logic              m_valid,
  output logic [NCH*DW-1:0] avg_out,
  output logic [NCH-1:0]    det,
  output logic [NCH-1:0]    det_pulse,
  output logic [NCH*OFW-1:0] of_cnt
);

  logic [NCH-1:0] m_valid_ch;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    adc_det_chan #(
      .HOLD_LEN(HOLDOFF),
      .OFW     (OFW)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_data   (s_data[c*DW +: DW]),
      .s_of     (s_of[c]),
      .thr_hi   (thr_hi),
      .thr_lo   (thr_lo),
      .of_clr   (of_clr),
      .m_valid  (m_valid_ch[c]),
      .avg_out  (avg_out[c*DW +: DW]),
      .det      (det[c]),
      .det_pulse(det_pulse[c]),
      .of_cnt   (of_cnt[c*OFW +: OFW])
    );
  end

  // All channels fill in lockstep, so their valid flags are identical.
  assign m_valid = &m_valid_ch;

endmodule

// File: tb/tb_adc_window_detector.sv
// Scoreboard bench for adc_window_detector: a behavioural model pushes expected
// averages/detections per sample; a negedge monitor pops and compares them.
module tb_adc_window_detector;

  localparam int NCH  = 3;
  localparam int DW   = 16;
  localparam int HOLD = 4;
  localparam int OFW  = 16;
  localparam int S_FILL = 0, S_ARMED = 1, S_ACTIVE = 2, S_HOLD = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid;
  logic [NCH*DW-1:0] s_data;
  logic [NCH-1:0]    s_of;
  logic [DW-1:0]     thr_hi, thr_lo;
  logic              of_clr;
  logic              m_valid;
  logic [NCH*DW-1:0] avg_out;
  logic [NCH-1:0]    det, det_pulse;
  logic [NCH*OFW-1:0] of_cnt;

  logic              sat_m_valid;
  logic [NCH*DW-1:0] sat_avg_out;
  logic [NCH-1:0]    sat_det, sat_det_pulse;
  logic [NCH*4-1:0]  sat_of_cnt;

  always #5 clk = ~clk;

  adc_window_detector #(.NCH(NCH), .HOLDOFF(HOLD), .OFW(OFW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_of(s_of),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .of_clr(of_clr), .m_valid(m_valid),
    .avg_out(avg_out), .det(det), .det_pulse(det_pulse), .of_cnt(of_cnt)
  );

  // Narrow counters so saturation is reachable in a few samples.
  adc_window_detector #(.NCH(NCH), .HOLDOFF(HOLD), .OFW(4)) dut_sat (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_of(s_of),
    .thr_hi(thr_hi), .thr_lo(thr_lo), .of_clr(of_clr), .m_valid(sat_m_valid),
    .avg_out(sat_avg_out), .det(sat_det), .det_pulse(sat_det_pulse), .of_cnt(sat_of_cnt)
  );

  typedef struct {
    logic              mv;
    logic [NCH*DW-1:0] avg;
    logic [NCH-1:0]    det;
    logic [NCH-1:0]    pulse;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model state
  int m_mem [NCH][8];
  int m_ptr [NCH];
  int m_sum [NCH];
  int m_st  [NCH];
  int m_hold[NCH];
  int m_fill;
  logic [NCH-1:0] m_det;
  int e_of  [NCH];
  int e_of4 [NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < 8; i++) m_mem[c][i] = 0;
      m_ptr[c] = 0; m_sum[c] = 0; m_st[c] = S_FILL; m_hold[c] = 0;
      e_of[c] = 0; e_of4[c] = 0;
    end
    m_fill = 0;
    m_det  = '0;
  endtask

  function automatic logic [63:0] pack_of(input int w);
    logic [63:0] v = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w == 16) v[c*16 +: 16] = 16'(e_of[c]);
      else         v[c*4 +: 4]   = 4'(e_of4[c]);
    end
    return v;
  endfunction

  task automatic send(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [DW-1:0] d2, input logic [NCH-1:0] of);
    exp_t r;
    logic [DW-1:0] d[NCH];
    int u, avg;
    logic rel;
    d[0] = d0; d[1] = d1; d[2] = d2;
    s_valid = 1'b1;
    s_data  = {d2, d1, d0};
    s_of    = of;
    if (m_fill < 8) m_fill++;
    r.mv    = (m_fill == 8);
    r.pulse = '0;
    r.avg   = '0;
    for (int c = 0; c < NCH; c++) begin
      u = int'(d[c] ^ 16'h8000);
      m_sum[c] = m_sum[c] + u - m_mem[c][m_ptr[c]];
      m_mem[c][m_ptr[c]] = u;
      m_ptr[c] = (m_ptr[c] + 1) % 8;
      avg = m_sum[c] >> 3;
      r.avg[c*DW +: DW] = DW'(avg);
`ifdef COMP_HYST_EN
      rel = (avg < int'(thr_lo));
`else
      rel = (avg <= int'(thr_hi));
`endif
      if (r.mv) begin
        case (m_st[c])
          S_FILL: m_st[c] = S_ARMED;
          S_ARMED: if (avg > int'(thr_hi)) begin
            m_st[c] = S_ACTIVE; m_det[c] = 1'b1; r.pulse[c] = 1'b1;
          end
          S_ACTIVE: if (rel) begin
            m_det[c] = 1'b0; m_hold[c] = 0;
            m_st[c] = (HOLD == 0) ? S_ARMED : S_HOLD;
          end
          default: if (m_hold[c] == HOLD - 1) m_st[c] = S_ARMED; else m_hold[c]++;
        endcase
      end
      if (of_clr) begin
        e_of[c] = 0; e_of4[c] = 0;
      end else if (of[c]) begin
        if (e_of[c] < 16'hFFFF) e_of[c]++;
        if (e_of4[c] < 15) e_of4[c]++;
      end
    end
    r.det = m_det;
    exp_q.push_back(r);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_of    = '0;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"},   m_valid,   0);
    check({tag, "_avg_out"},   avg_out,   0);
    check({tag, "_det"},       det,       0);
    check({tag, "_det_pulse"}, det_pulse, 0);
    check({tag, "_of_cnt"},    of_cnt,    0);
    check({tag, "_sat_of"},    sat_of_cnt, 0);
  endtask

  // Monitor: one record per accepted sample; det/det_pulse checked a cycle later.
  logic sv_seen;
  logic det_pend = 1'b0;
  exp_t cur, pend;

  always @(posedge clk or posedge rst) begin
    if (rst) sv_seen <= 1'b0;
    else     sv_seen <= s_valid;
  end

  always @(negedge clk) begin
    if (rst) begin
      det_pend = 1'b0;
    end else begin
      if (det_pend) begin
        check("det", det, pend.det);
        check("det_pulse", det_pulse, pend.pulse);
        det_pend = 1'b0;
      end else begin
        check("det_pulse_idle", det_pulse, 0);
      end
      if (sv_seen) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("m_valid", m_valid, cur.mv);
          if (cur.mv) check("avg_out", avg_out, cur.avg);
          pend     = cur;
          det_pend = 1'b1;
        end
      end else begin
        check("m_valid_idle", m_valid, 0);
      end
    end
  end

  initial begin
    s_valid = 1'b0; s_data = '0; s_of = '0; of_clr = 1'b0;
    thr_hi = 16'hA000; thr_lo = 16'h9000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Fill with signed zero: average settles at 0x8000.
    repeat (8) send(16'h0000, 16'h0000, 16'h0000, '0);
    idle(2);

    // ch0 step to 0x3000 crosses 0xA000 on the 6th sample.
    repeat (10) send(16'h3000, 16'h0000, 16'h0000, '0);
    // Partial drop then full drop: release behaviour depends on COMP_HYST_EN.
    repeat (10) send(16'h1800, 16'h0000, 16'h0000, '0);
    repeat (10) send(16'h0000, 16'h0000, 16'h0000, '0);
    idle(2);

    // ch2 holdoff: trigger, release, re-cross inside holdoff, then after it.
    repeat (3) send(16'h0000, 16'h0000, 16'h7FFF, '0);
    repeat (2) send(16'h0000, 16'h0000, 16'h8000, '0);
    repeat (8) send(16'h0000, 16'h0000, 16'h7FFF, '0);
    idle(2);

    // Overflow counting, qualification, clear priority and saturation.
    repeat (3) send(16'h0000, 16'h0000, 16'h7FFF, 3'b010);
    idle(2);
    check("of_cnt_three", of_cnt, pack_of(16));
    s_of = 3'b111;
    idle(2);
    s_of = '0;
    check("of_cnt_unqualified", of_cnt, pack_of(16));
    of_clr = 1'b1;
    send(16'h0000, 16'h0000, 16'h7FFF, 3'b010);
    of_clr = 1'b0;
    idle(1);
    check("of_cnt_clr_priority", of_cnt, pack_of(16));
    repeat (20) send(16'h0000, 16'h0000, 16'h7FFF, 3'b001);
    idle(2);
    check("of_cnt_twenty", of_cnt, pack_of(16));
    check("of_cnt_saturated", sat_of_cnt, pack_of(4));

    // Reset mid-stream while ch0 is detecting.
    repeat (12) send(16'h3000, 16'h0000, 16'h0000, 3'b100);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Refill: no detection until the window is full again.
    repeat (12) send(16'h3000, 16'h0000, 16'h0000, '0);
    idle(3);
    check("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/adc_window_detector.md
# adc_window_detector

Multi-channel successor to the single-channel ADC comparator in the front-end acquisition path. Each of NCH two's-complement ADC channels is converted to offset binary and averaged over a 2^LOG2_WIN sample moving window. The average is compared against a programmable threshold pair, and a per-channel state machine applies hysteresis and a re-trigger holdoff. The block feeds the trigger/event logic and exports per-channel averages and ADC overflow counts for monitoring.

## Interface
- NCH, 3, number of ADC channels
- DW, 16, sample width (two's complement in, offset binary out)
- LOG2_WIN, 3, log2 of moving-average window depth (window = 8)
- HOLDOFF, 4, valid samples ignored after a detection ends (0 = none)
- OFW, 16, width of per-channel overflow counter
- clk  in  1  sample clock
- rst  in  1  reset, asynchronous, active-high
- s_valid  in  1  one sample per channel present this cycle
- s_data  in  NCH*DW  packed samples, channel 0 in LSBs
- s_of  in  NCH  ADC overflow flag per channel, qualified by s_valid
- thr_hi  in  DW  trigger threshold, offset binary
- thr_lo  in  DW  release threshold, offset binary (used only with COMP_HYST_EN)
- of_clr  in  1  synchronous clear of all overflow counters
- m_valid  out  1  avg_out updated with a full window
- avg_out  out  NCH*DW  per-channel window average, offset binary
- det  out  NCH  level detection per channel
- det_pulse  out  NCH  one-cycle pulse on det rising
- of_cnt  out  NCH*OFW  saturating overflow counts

## Operation
- Conversion: u = s XOR (1 << (DW-1)). Signed 0x0000 becomes 0x8000; 0x8000 becomes 0x0000.
- Window: per-channel circular buffer of 2^LOG2_WIN words. On s_valid, sum <= sum + u_new - u_oldest.
  - Sum width is DW+LOG2_WIN. No overflow is possible, so no saturation.
  - avg = sum >> LOG2_WIN (truncate).
- Fill counter counts to 2^LOG2_WIN and then stops. m_valid stays low until the window is full.
- FSM per channel (all transitions evaluated only on a cycle carrying a new average):
  - FILL: wait for the window to be full, then go to ARMED.
  - ARMED: if avg > thr_hi, go to ACTIVE; set det=1 and pulse det_pulse.
  - ACTIVE: release on avg < thr_lo (COMP_HYST_EN) or avg <= thr_hi (no macro); then det=0 and go to HOLDOFF, or to ARMED if HOLDOFF=0.
  - HOLDOFF: count HOLDOFF valid samples with the compare ignored, then go to ARMED.
- Comparisons are unsigned. Thresholds are sampled on the same cycle as the average they are compared with. A threshold change mid-run takes effect on the next average.
- Overflow: of_cnt[c] increments on s_valid && s_of[c] and saturates at all-ones.
  - of_clr has priority over a simultaneous increment; the result is 0.
- Reset values:
  - Window memory, sums, fill counts and of_cnt: 0.
  - Outputs m_valid, avg_out, det, det_pulse: 0.
  - FSM: FILL.
- Reset mid-operation clears everything above. A full window must refill before det can assert again.
- s_valid low: no state change, and m_valid and det_pulse are 0.

## Timing
- Sample accepted on edge E (s_valid=1). The sum and avg_out register at E; m_valid is high in the cycle after E.
- The FSM registers at E+1, so det and det_pulse change one cycle after m_valid. Sample-to-det latency is 2 clocks.
- Back-to-back s_valid is supported at full rate, with no stalls and no backpressure.
- det_pulse is exactly one cycle wide, coincident with det rising.

## Configuration
- COMP_HYST_EN defined: release threshold is thr_lo. thr_lo > thr_hi is legal but yields immediate release.
- COMP_HYST_EN undefined: single-threshold behaviour; thr_lo is ignored and the release compare uses thr_hi.

## Structure
- Package adc_det_pkg holds:
  - the FSM state enum (FILL, ARMED, ACTIVE, HOLDOFF);
  - the to_offset_binary function;
  - localparams WIN = 1 << LOG2_WIN and SUMW = DW + LOG2_WIN.
- Sub-module adc_det_chan contains the window buffer, sum, fill counter, FSM and overflow counter for one channel. The top level instantiates NCH copies with a generate loop and packs the outputs.

## Test plan
- Reset: assert rst mid-stream → all outputs 0 immediately; after release, m_valid stays low for the first 7 valid samples and goes high after the 8th.
- Fill: 8 samples of 0x0000 on all channels → avg_out = 0x8000 per channel, det = 0.
- Trigger: thr_hi=0xA000; after fill, ch0 steps to 0x3000 (0xB000 offset) → avg rises by 0x600 per sample; at sample 6, avg=0xA400; det[0] and det_pulse[0] assert 2 clocks later; ch1 and ch2 stay 0.
- Hysteresis (macro on, thr_lo=0x9000): from ACTIVE, input 0x1800 (avg settles at 0x9800) → det holds; input 0x0000 → det falls once avg < 0x9000. Macro off: det falls at the first avg ≤ 0xA000.
- Holdoff (HOLDOFF=4): re-crossing thr_hi within 4 valid samples after release → no det_pulse; a crossing on the 5th sample → det_pulse.
- Overflow: 3 pulses of s_of[1] with s_valid → of_cnt ch1 = 3, others 0; of_clr together with s_of[1] → 0; forcing the count to 0xFFFF and pulsing once more → stays 0xFFFF.
